alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the combinational TP1 ALU. Accepts operand/opcode

---
 rtl/alu_pipe.sv | 133 +++++++++++++
 tb/tb_alu_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures the operand/opcode triple; stage 2 holds the result, the {Z,N,C,V} flags and the illegal-opcode flag.
module alu_pipe #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  input  logic [NB_OP-1:0]   i_operation,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_result,
  output logic [3:0]         o_flags,
  output logic               o_err
);

  localparam int NB_SH = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int MSB   = NB_DATA - 1;

  localparam logic [NB_DATA-1:0] SH_LIMIT = NB_DATA'(NB_DATA);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  logic               s1_valid;
  logic [NB_DATA-1:0] s1_a;
  logic [NB_DATA-1:0] s1_b;
  logic [NB_OP-1:0]   s1_op;
  logic               s2_valid;
  logic               en1;
  logic               en2;

  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   diff;
  logic [NB_SH-1:0]   sh;
  logic               sh_big;
  logic [NB_DATA-1:0] res;
  logic               carry;
  logic               ovf;
  logic               illegal;
  logic [3:0]         flags;

  // A stage may load when its downstream neighbour can take its current content.
  assign en2     = ~s2_valid | i_ready;
  assign en1     = ~s1_valid | en2;
  assign o_ready = en1;
  assign o_valid = s2_valid;

  // The extra top bit of diff is the borrow: it is set exactly when A < B unsigned.
  assign sum    = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff   = {1'b0, s1_a} - {1'b0, s1_b};
  assign sh_big = (s1_b >= SH_LIMIT);
  assign sh     = s1_b[NB_SH-1:0];

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res   = sum[MSB:0];
        carry = sum[NB_DATA];
        ovf   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        res   = diff[MSB:0];
        carry = diff[NB_DATA];
        ovf   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
      OP_NOR: res = ~(s1_a | s1_b);
      OP_SRL: begin
        if (sh_big) res = '0;
        else        res = s1_a >> sh;
      end
      OP_SRA: begin
        // Kept as an if/else: in a ?: next to an unsigned operand the shift would lose its sign fill.
        if (sh_big) res = {NB_DATA{s1_a[MSB]}};
        else        res = $signed(s1_a) >>> sh;
      end
      default: illegal = 1'b1;
    endcase
    flags = illegal ? 4'b0000 : {(res == '0), res[MSB], carry, ovf};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (en1) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_a  <= i_datoA;
        s1_b  <= i_datoB;
        s1_op <= i_operation;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      o_result <= '0;
      o_flags  <= 4'b0000;
      o_err    <= 1'b0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= res;
        o_flags  <= flags;
        o_err    <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes expected responses, the monitor pops and compares on every output transfer.
module tb_alu_pipe;

  localparam int W = 8;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_datoA;
  logic [W-1:0] i_datoB;
  logic [5:0]   i_operation;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic [3:0]   o_flags;
  logic         o_err;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_ready = 1'b0;

  alu_pipe #(.NB_DATA(W), .NB_OP(6)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_datoA     (i_datoA),
    .i_datoB     (i_datoB),
    .i_operation (i_operation),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_flags     (o_flags),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: flags from integer arithmetic and signed-range overflow.
  function automatic exp_t model(input int a, input int b, input logic [5:0] op);
    exp_t x;
    int   sa, sb, s, r;
    bit   c, v, legal;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = 0; c = 0; v = 0; legal = 1;
    case (op)
      ADD: begin s = a + b; r = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      SUB: begin r = (a - b + 256) % 256; c = (a < b); v = (sa - sb > 127) || (sa - sb < -128); end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      NOR: r = 255 - (a | b);
      SRL: r = (b >= W) ? 0 : a / (1 << b);
      SRA: r = (b >= W) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
      default: legal = 0;
    endcase
    x.r = W'(r);
    x.f = legal ? {(r == 0), (r > 127), c, v} : 4'b0000;
    x.e = !legal;
    return x;
  endfunction

  // Issues one triple, waiting (bounded) for o_ready; called just after a rising edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op, input exp_t e);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    i_valid = 1'b1;
    i_datoA = a;
    i_datoB = b;
    i_operation = op;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    i_valid = 1'b0;
    if (acc) sb_q.push_back(e);
    else     check("accept_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic drive_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] op);
    drive(a, b, op, model(int'(a), int'(b), op));
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (sb_q.size() != 0 && tries < 200) begin
      @(posedge clk);
      #1;
      tries++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares the head while o_valid is up (also proves stability under stall), pops on transfer.
  always @(negedge clk) begin
    if (i_rst_n === 1'b1) begin
      check("o_ready", {31'b0, o_ready}, {31'b0, !(sb_q.size() == 2 && !i_ready)});
      if (o_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_o_valid", {31'b0, o_valid}, 32'd0);
        end else begin
          check("result_flags_err", {19'b0, o_result, o_flags, o_err}, {19'b0, sb_q[0]});
          if (i_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    logic [W-1:0] a, b;
    ops = '{ADD, SUB, AND, OR, XOR, NOR, SRA, SRL, BAD};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_datoA = '0;
    i_datoB = '0;
    i_operation = '0;
    #3;
    check("reset_o_valid", {31'b0, o_valid}, 32'd0);
    check("reset_o_ready", {31'b0, o_ready}, 32'd1);
    check("reset_outputs", {19'b0, o_result, o_flags, o_err}, 32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1 with latency: accepted at this edge, visible only after the second edge.
    drive(8'hFF, 8'h01, ADD, '{r: 8'h00, f: 4'b1010, e: 1'b0});
    @(negedge clk);
    check("latency_one_edge", {31'b0, o_valid}, 32'd0);
    @(negedge clk);
    check("latency_two_edges", {31'b0, o_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // T2..T4 back to back with i_ready held high.
    drive(8'h7F, 8'h01, ADD, '{r: 8'h80, f: 4'b0101, e: 1'b0});
    drive(8'h03, 8'h05, SUB, '{r: 8'hFE, f: 4'b0110, e: 1'b0});
    drive(8'h90, 8'h02, SRA, '{r: 8'hE4, f: 4'b0100, e: 1'b0});
    drive(8'h90, 8'h02, SRL, '{r: 8'h24, f: 4'b0000, e: 1'b0});
    drive(8'h90, 8'h09, SRA, '{r: 8'hFF, f: 4'b0100, e: 1'b0});
    drive(8'h90, 8'h09, SRL, '{r: 8'h00, f: 4'b1000, e: 1'b0});
    drive(8'h12, 8'h34, BAD, '{r: 8'h00, f: 4'b0000, e: 1'b1});
    drive(8'h0F, 8'hF0, AND, '{r: 8'h00, f: 4'b1000, e: 1'b0});
    drive(8'h0F, 8'hF0, NOR, '{r: 8'h00, f: 4'b1000, e: 1'b0});
    drive(8'h80, 8'h01, SUB, '{r: 8'h7F, f: 4'b0001, e: 1'b0});
    drain();

    // T5: random triples with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 8)];
      a = W'($urandom_range(0, 255));
      if (op == SRA || op == SRL) b = W'($urandom_range(0, 11));
      else                        b = W'($urandom_range(0, 255));
      drive_m(a, b, op);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    drain();

    // T6: reset with two triples in flight.
    i_ready = 1'b0;
    drive_m(8'h11, 8'h22, ADD);
    drive_m(8'h33, 8'h44, XOR);
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_reset_o_valid", {31'b0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    check("post_reset_o_ready", {31'b0, o_ready}, 32'd1);
    repeat (5) @(negedge clk);
    check("no_stale_result", {31'b0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    drive_m(8'hC0, 8'h40, ADD);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
